score_board_reader: RTL and testbench

- Read side of the player high-score store: fetches every player's personal best through a synchronous read port and streams a ranked leaderboard, highest score first.
- Sits between the score RAM and the display/UART formatting logic.
- One ranked entry is presented per valid/ready handshake.
- Done pulses after the last entry.

---
 rtl/score_board_reader.sv | 211 +++++++++++++++++++++
 tb/tb_score_board_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_board_reader.sv
// ============================================================================
// Module   : score_board_reader
// Purpose  : Reads every player's personal best from the score store, then
//            streams a ranked leaderboard (highest first) over valid/ready.
// Options  : SCORE_BOARD_SKIP_ZERO_EN - when defined, zero scores are skipped
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_board_reader #(
    parameter int NUM_PLAYERS = 5,
    parameter int SCORE_W     = 7,
    parameter int ID_W        = 3
) (
    input  logic               Clk_i,
    input  logic               Reset_i,
    input  logic               Start_i,
    output logic               Rd_En_o,
    output logic [ID_W-1:0]    Rd_Addr_o,
    input  logic [SCORE_W-1:0] Rd_Data_i,
    output logic               Out_Valid_o,
    input  logic               Out_Ready_i,
    output logic [ID_W-1:0]    Out_Rank_o,
    output logic [ID_W-1:0]    Out_Player_ID_o,
    output logic [SCORE_W-1:0] Out_Score_o,
    output logic               Busy_o,
    output logic               Done_o
);

    // One extra bit so that counters can reach NUM_PLAYERS even when
    // 2**ID_W == NUM_PLAYERS.
    localparam int               CNT_W      = ID_W + 1;
    localparam logic [CNT_W-1:0] C_N        = CNT_W'(NUM_PLAYERS);
    localparam logic [CNT_W-1:0] C_N_M1     = CNT_W'(NUM_PLAYERS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_SELECT = 3'd2,
        S_EMIT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                 state_q;
    logic [SCORE_W-1:0]     buf_q [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] emitted_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       rank_q;
    logic                   pend_q;
    logic [ID_W-1:0]        pend_addr_q;
    logic                   best_found_q;
    logic [ID_W-1:0]        best_id_q;
    logic [SCORE_W-1:0]     best_score_q;

    logic                   rd_en_q;
    logic [ID_W-1:0]        rd_addr_q;
    logic                   out_valid_q;
    logic [ID_W-1:0]        out_rank_q;
    logic [ID_W-1:0]        out_id_q;
    logic [SCORE_W-1:0]     out_score_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   state_legal_d;
    logic [ID_W-1:0]        scan_id_d;
    logic [SCORE_W-1:0]     scan_score_d;
    logic                   scan_elig_d;
    logic                   take_d;
    logic                   found_d;
    logic [ID_W-1:0]        best_id_d;
    logic [SCORE_W-1:0]     best_score_d;

    // Running-maximum step for the entry currently addressed by the scan.
    always_comb begin
        state_legal_d = state_q inside {S_IDLE, S_FETCH, S_SELECT, S_EMIT, S_FINISH};
        scan_id_d     = cnt_q[ID_W-1:0];
        scan_score_d  = buf_q[scan_id_d];
        scan_elig_d   = !emitted_q[scan_id_d];
`ifdef SCORE_BOARD_SKIP_ZERO_EN
        if (scan_score_d == '0) begin
            scan_elig_d = 1'b0;
        end
`endif
        // Strict greater-than keeps the earlier (lower) ID on ties.
        take_d        = scan_elig_d && (!best_found_q || (scan_score_d > best_score_q));
        found_d       = best_found_q || take_d;
        best_id_d     = take_d ? scan_id_d    : best_id_q;
        best_score_d  = take_d ? scan_score_d : best_score_q;
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i || !state_legal_d) begin
            state_q      <= S_IDLE;
            emitted_q    <= '0;
            cnt_q        <= '0;
            rank_q       <= '0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            best_found_q <= 1'b0;
            best_id_q    <= '0;
            best_score_q <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            out_valid_q  <= 1'b0;
            out_rank_q   <= '0;
            out_id_q     <= '0;
            out_score_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            done_q      <= 1'b0;
            // Read data returns one cycle after the strobe; remember the address.
            pend_q      <= rd_en_q;
            pend_addr_q <= rd_addr_q;
            if (pend_q) begin
                buf_q[pend_addr_q] <= Rd_Data_i;
            end

            case (state_q)
                S_IDLE: begin
                    if (Start_i) begin
                        state_q   <= S_FETCH;
                        busy_q    <= 1'b1;
                        emitted_q <= '0;
                        rank_q    <= '0;
                        cnt_q     <= '0;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end
                end

                S_FETCH: begin
                    if (cnt_q < C_N_M1) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= ID_W'(cnt_q + 1'b1);
                    end else begin
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                    end
                    if (cnt_q == C_N) begin
                        state_q      <= S_SELECT;
                        cnt_q        <= '0;
                        best_found_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_SELECT: begin
                    best_found_q <= found_d;
                    best_id_q    <= best_id_d;
                    best_score_q <= best_score_d;
                    if (cnt_q == C_N_M1) begin
                        cnt_q <= '0;
                        if (found_d) begin
                            state_q     <= S_EMIT;
                            out_valid_q <= 1'b1;
                            out_rank_q  <= rank_q[ID_W-1:0];
                            out_id_q    <= best_id_d;
                            out_score_q <= best_score_d;
                        end else begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_EMIT: begin
                    if (Out_Ready_i) begin
                        emitted_q[out_id_q] <= 1'b1;
                        rank_q              <= rank_q + 1'b1;
                        out_valid_q         <= 1'b0;
                        best_found_q        <= 1'b0;
                        if ((rank_q + 1'b1) == C_N) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SELECT;
                        end
                    end
                end

                S_FINISH: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Rd_En_o         = rd_en_q;
    assign Rd_Addr_o       = rd_addr_q;
    assign Out_Valid_o     = out_valid_q;
    assign Out_Rank_o      = out_rank_q;
    assign Out_Player_ID_o = out_id_q;
    assign Out_Score_o     = out_score_q;
    assign Busy_o          = busy_q;
    assign Done_o          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_score_board_reader.sv
// ============================================================================
// Module   : tb_score_board_reader
// Purpose  : Directed self-checking bench for score_board_reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_board_reader;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Rd_En;
    logic [2:0] Rd_Addr;
    logic [6:0] Rd_Data;
    logic       Out_Valid;
    logic       Out_Ready;
    logic [2:0] Out_Rank;
    logic [2:0] Out_Player_ID;
    logic [6:0] Out_Score;
    logic       Busy;
    logic       Done;

    score_board_reader dut (
        .Clk_i           (Clk),
        .Reset_i         (Reset),
        .Start_i         (Start),
        .Rd_En_o         (Rd_En),
        .Rd_Addr_o       (Rd_Addr),
        .Rd_Data_i       (Rd_Data),
        .Out_Valid_o     (Out_Valid),
        .Out_Ready_i     (Out_Ready),
        .Out_Rank_o      (Out_Rank),
        .Out_Player_ID_o (Out_Player_ID),
        .Out_Score_o     (Out_Score),
        .Busy_o          (Busy),
        .Done_o          (Done)
    );

    always #5 Clk = ~Clk;

    // Synchronous-read score store model
    logic [6:0] mem [5];
    int         reads_total = 0;
    always @(posedge Clk) begin
        if (Rd_En) begin
            Rd_Data     <= mem[Rd_Addr];
            reads_total <= reads_total + 1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    int got_n, dones, lat, unstable, busy1, reads_start, hs;
    int got_pack [8];
    int exp_id [5];
    int exp_sc [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts a scan and watches 70 cycles; optional stall on the first entry
    // and an optional Start pulse while the first entry is presented.
    task automatic run_scan(input int stall, input bit poke);
        int  left;
        bit  poked;
        int  snap;
        got_n       = 0;
        dones       = 0;
        lat         = 0;
        unstable    = 0;
        left        = stall;
        poked       = 1'b0;
        snap        = 0;
        reads_start = reads_total;
        Out_Ready   = 1'b1;
        Start       = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(posedge Clk); #1;
            Start = 1'b0;
            if (c == 1) busy1 = int'(Busy);
            if (Done) dones++;
            if (Out_Valid) begin
                if (lat == 0) begin
                    lat  = c;
                    snap = (int'(Out_Rank) << 10) | (int'(Out_Player_ID) << 7) | int'(Out_Score);
                end
                if (poke && !poked) begin
                    Start = 1'b1;
                    poked = 1'b1;
                end
                if (left > 0) begin
                    if (((int'(Out_Rank) << 10) | (int'(Out_Player_ID) << 7) | int'(Out_Score)) != snap)
                        unstable++;
                    Out_Ready = 1'b0;
                    left--;
                end else begin
                    Out_Ready = 1'b1;
                end
            end else begin
                Out_Ready = 1'b1;
            end
            if (Out_Valid && Out_Ready) begin
                if (got_n < 8)
                    got_pack[got_n] = (int'(Out_Rank) << 10) | (int'(Out_Player_ID) << 7) | int'(Out_Score);
                got_n++;
            end
        end
        Start     = 1'b0;
        Out_Ready = 1'b1;
    endtask

    task automatic verify(input string tag, input int n);
        chk({tag, " count"}, got_n, n);
        chk({tag, " done"}, dones, 1);
        chk({tag, " busy1"}, busy1, 1);
        chk({tag, " reads"}, reads_total - reads_start, 5);
        chk({tag, " busy_end"}, int'(Busy), 0);
        if (n > 0) chk({tag, " latency"}, lat, 12);
        for (int i = 0; i < n && i < 8; i++)
            chk($sformatf("%s entry%0d", tag, i), got_pack[i], (i << 10) | (exp_id[i] << 7) | exp_sc[i]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " Rd_En"}, Rd_En, 0);
        chk({tag, " Rd_Addr"}, Rd_Addr, 0);
        chk({tag, " Out_Valid"}, Out_Valid, 0);
        chk({tag, " Out_Rank"}, Out_Rank, 0);
        chk({tag, " Out_Player_ID"}, Out_Player_ID, 0);
        chk({tag, " Out_Score"}, Out_Score, 0);
        chk({tag, " Busy"}, Busy, 0);
        chk({tag, " Done"}, Done, 0);
    endtask

    initial begin
        Reset     = 1'b1;
        Start     = 1'b0;
        Out_Ready = 1'b0;
        mem       = '{7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        repeat (3) @(posedge Clk);
        #1;
        chk_reset_vals("reset");
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Distinct scores, free-flowing consumer
        mem    = '{7'd10, 7'd40, 7'd25, 7'd5, 7'd33};
        exp_id = '{1, 4, 2, 0, 3};
        exp_sc = '{40, 33, 25, 10, 5};
        run_scan(0, 1'b0);
        verify("basic", 5);

        // Ties resolve to the lowest player ID
        mem    = '{7'd20, 7'd50, 7'd50, 7'd20, 7'd7};
        exp_id = '{1, 2, 0, 3, 4};
        exp_sc = '{50, 50, 20, 20, 7};
        run_scan(0, 1'b0);
        verify("ties", 5);

        // Backpressure on rank 0
        mem    = '{7'd10, 7'd40, 7'd25, 7'd5, 7'd33};
        exp_id = '{1, 4, 2, 0, 3};
        exp_sc = '{40, 33, 25, 10, 5};
        run_scan(4, 1'b0);
        verify("stall", 5);
        chk("stall stable", unstable, 0);

        // Start during EMIT is ignored
        run_scan(0, 1'b1);
        verify("poke", 5);

        // Reset while selecting rank 2
        Out_Ready = 1'b1;
        Start     = 1'b1;
        hs        = 0;
        for (int c = 0; c < 60 && hs < 2; c++) begin
            @(posedge Clk); #1;
            Start = 1'b0;
            if (Out_Valid && Out_Ready) hs++;
        end
        chk("abort reached rank1", hs, 2);
        repeat (2) begin @(posedge Clk); #1; end
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk_reset_vals("abort");
        dones = 0;
        got_n = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge Clk); #1;
            if (Done) dones++;
            if (Out_Valid) got_n++;
        end
        chk("abort no done", dones, 0);
        chk("abort no valid", got_n, 0);
        mem    = '{7'd20, 7'd50, 7'd50, 7'd20, 7'd7};
        exp_id = '{1, 2, 0, 3, 4};
        exp_sc = '{50, 50, 20, 20, 7};
        run_scan(0, 1'b0);
        verify("after_abort", 5);

        // Zero scores
        mem = '{7'd0, 7'd12, 7'd0, 7'd0, 7'd3};
`ifdef SCORE_BOARD_SKIP_ZERO_EN
        exp_id = '{1, 4, 0, 0, 0};
        exp_sc = '{12, 3, 0, 0, 0};
        run_scan(0, 1'b0);
        verify("zeros", 2);
        mem = '{7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        run_scan(0, 1'b0);
        verify("allzero", 0);
`else
        exp_id = '{1, 4, 0, 2, 3};
        exp_sc = '{12, 3, 0, 0, 0};
        run_scan(0, 1'b0);
        verify("zeros", 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
